crc_checker: RTL

//  Serial CRC receiver/checker; the far end of the serial CRC generator link.

---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc_checker_if.sv | 43 ++++
 rtl/crc_lfsr.sv | 42 ++++
 rtl/crc_checker.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared CRC link definitions: LFSR geometry and checker/generator FSM states.
// Used by crc_checker and crc_lfsr.
package crc_pkg;

  localparam int WIDTH     = 8;
  localparam int DATA_BITS = 8;
  localparam int CNT_W     = 3;

  localparam logic [WIDTH-1:0] SEED = 8'hD8;
  localparam logic [WIDTH-1:0] TAPS = 8'h44;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    WAIT_CRC,
    CRC,
    ABORT
  } crc_state_e;

endpackage

// File: rtl/crc_checker_if.sv
// Serial receive side of the CRC link plus checker result bus.
// The err_cnt signal exists only when CRC_CHK_ERR_CNT_EN is defined.
interface crc_checker_if;
  import crc_pkg::*;

  logic                 data;
  logic                 active;
  logic                 crc_in;
  logic                 crc_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 done;
  logic                 crc_err;
`ifdef CRC_CHK_ERR_CNT_EN
  logic [7:0]           err_cnt;
`endif

  modport master (
    output data,
    output active,
    output crc_in,
    output crc_valid,
    input  rx_data,
    input  done,
    input  crc_err
`ifdef CRC_CHK_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  data,
    input  active,
    input  crc_in,
    input  crc_valid,
    output rx_data,
    output done,
    output crc_err
`ifdef CRC_CHK_ERR_CNT_EN
    , output err_cnt
`endif
  );

endinterface

// File: rtl/crc_lfsr.sv
// Galois-style CRC LFSR: seed load, data step, plain right shift.
// Only the LSB leaves the block; both link ends consume the CRC serially.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int             W      = WIDTH,
  parameter logic [W-1:0]   SEED_P = SEED,
  parameter logic [W-1:0]   TAPS_P = TAPS
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic step,
  input  logic shift,
  input  logic din,
  output logic lsb
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;
  logic         fb;

  assign fb  = din ^ lfsr_q[0];
  assign lsb = lfsr_q[0];

  always_comb begin
    lfsr_d = lfsr_q;
    unique case (1'b1)
      load:  lfsr_d = SEED_P;
      step:  lfsr_d = {fb, lfsr_q[W-1:1]
                       ^ (TAPS_P[W-2:0] & {(W-1){fb}})};
      shift: lfsr_d = {1'b0, lfsr_q[W-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= SEED_P;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/crc_checker.sv
// Serial CRC receiver: deserialise payload, recompute CRC, check trailer.
// Optional saturating error counter behind CRC_CHK_ERR_CNT_EN.
module crc_checker
  import crc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  crc_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  crc_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 done_q;
  logic                 crc_err_q;
  logic                 mism_q;

  logic lfsr_load;
  logic lfsr_step;
  logic lfsr_shift;
  logic lfsr_lsb;
  logic bit_err;

  assign bit_err = bus.crc_in ^ lfsr_lsb;

  // Any abort or completed frame reseeds, so IDLE/ABORT see SEED.
  always_comb begin
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    lfsr_shift = 1'b0;
    unique case (state_q)
      IDLE, ABORT: lfsr_step = bus.active;
      DATA: begin
        lfsr_step = bus.active;
        lfsr_load = !bus.active;
      end
      WAIT_CRC: lfsr_shift = bus.crc_valid;
      CRC: begin
        lfsr_shift = bus.crc_valid && (cnt_q != LAST_C);
        lfsr_load  = !(bus.crc_valid && (cnt_q != LAST_C));
      end
      default: ;
    endcase
  end

  crc_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .shift (lfsr_shift),
    .din   (bus.data),
    .lsb   (lfsr_lsb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      mism_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      crc_err_q <= 1'b0;
      unique case (state_q)
        IDLE, ABORT: begin
          if (bus.active) begin
            shreg_q[0] <= bus.data;
            cnt_q      <= ONE;
            state_q    <= DATA;
          end else begin
            cnt_q      <= '0;
            state_q    <= IDLE;
          end
        end
        DATA: begin
          if (bus.active) begin
            shreg_q[cnt_q] <= bus.data;
            if (cnt_q == LAST_D) begin
              cnt_q   <= '0;
              state_q <= WAIT_CRC;
            end else begin
              cnt_q   <= cnt_q + ONE;
            end
          end else begin
            cnt_q     <= '0;
            state_q   <= ABORT;
            done_q    <= 1'b1;
            crc_err_q <= 1'b1;
          end
        end
        WAIT_CRC: begin
          if (bus.crc_valid) begin
            mism_q  <= bit_err;
            cnt_q   <= ONE;
            state_q <= CRC;
          end
        end
        CRC: begin
          if (bus.crc_valid) begin
            if (cnt_q == LAST_C) begin
              cnt_q     <= '0;
              state_q   <= IDLE;
              done_q    <= 1'b1;
              crc_err_q <= mism_q | bit_err;
              rx_data_q <= shreg_q;
            end else begin
              mism_q    <= mism_q | bit_err;
              cnt_q     <= cnt_q + ONE;
            end
          end else begin
            cnt_q     <= '0;
            state_q   <= ABORT;
            done_q    <= 1'b1;
            crc_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.done    = done_q;
  assign bus.crc_err = crc_err_q;

`ifdef CRC_CHK_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_q && crc_err_q && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule
